// File: rtl/bsg_tag_serializer_pkg.sv
// Shared command type, FSM encodings and helpers for the bsg_tag packet serializer.
`ifndef BSG_TAG_SERIALIZER_PKG_SV
`define BSG_TAG_SERIALIZER_PKG_SV

`define BSG_TAG_CMD_DECLARE(lg_els, lg_width, max_payload) \
    typedef struct packed { \
        logic [lg_els-1:0]      nodeid; \
        logic                   data_not_reset; \
        logic [lg_width-1:0]    len; \
        logic [max_payload-1:0] payload; \
    } bsg_tag_cmd_s

package bsg_tag_serializer_pkg;

    typedef logic [2:0] tag_state_t;

    localparam tag_state_t ST_IDLE    = 3'd0;
    localparam tag_state_t ST_START   = 3'd1;
    localparam tag_state_t ST_NODE    = 3'd2;
    localparam tag_state_t ST_DNR     = 3'd3;
    localparam tag_state_t ST_LEN     = 3'd4;
    localparam tag_state_t ST_PAYLOAD = 3'd5;
    localparam tag_state_t ST_GAP     = 3'd6;

    // Enabled cycles of one packet: start bit, node id, dnr flag, length, payload.
    function automatic int packet_len(input int lg_els, input int lg_width, input int len);
        return 2 + lg_els + lg_width + len;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`endif

// File: rtl/bsg_tag_piso.sv
// Parallel-in serial-out shifter; the serial bit is itself a flop so it can drive a pin directly.
module bsg_tag_piso
#(
    parameter int width_p = 15
)
(
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               load_i,
    input  logic               shift_i,
    input  logic [width_p-1:0] data_i,
    output logic               bit_o
);

    logic [width_p-1:0] shreg_q, shreg_d;
    logic               bit_q, bit_d;

    // Load presents data_i[0] on the next cycle; each shift then exposes the next higher bit.
    always_comb begin
        shreg_d = shreg_q;
        bit_d   = bit_q;
        if (load_i) begin
            bit_d   = data_i[0];
            shreg_d = data_i >> 1;
        end else if (shift_i) begin
            bit_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            shreg_q <= '0;
            bit_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
        end
    end

    assign bit_o = bit_q;

endmodule

// File: rtl/bsg_tag_packet_serializer.sv
// Host-side bsg_tag packet generator: one accepted command becomes one serial packet on tag data/enable.
module bsg_tag_packet_serializer
    import bsg_tag_serializer_pkg::*;
#(
    parameter int els_p        = 32,
    parameter int lg_width_p   = 4,
    parameter int gap_cycles_p = 2,
    localparam int lg_els_lp      = $clog2(els_p),
    localparam int max_payload_lp = (1 << lg_width_p) - 1
)
(
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      v_i,
    input  logic [lg_els_lp-1:0]      nodeid_i,
    input  logic                      data_not_reset_i,
    input  logic [lg_width_p-1:0]     len_i,
    input  logic [max_payload_lp-1:0] payload_i,
    output logic                      ready_o,
    output logic                      tag_data_o,
    output logic                      tag_en_o,
    output logic                      busy_o
);

    `BSG_TAG_CMD_DECLARE(lg_els_lp, lg_width_p, max_payload_lp);

    localparam int cnt_w_lp = max_int(max_int($clog2(max_payload_lp + 1), lg_els_lp),
                                      max_int(lg_width_p, $clog2(gap_cycles_p + 1)));

    localparam logic [cnt_w_lp-1:0] node_cnt_lp = cnt_w_lp'(lg_els_lp - 1);
    localparam logic [cnt_w_lp-1:0] len_cnt_lp  = cnt_w_lp'(lg_width_p - 1);
    localparam logic [cnt_w_lp-1:0] gap_cnt_lp  = cnt_w_lp'((gap_cycles_p > 0) ? gap_cycles_p - 1 : 0);
    localparam tag_state_t          after_pkt_lp = (gap_cycles_p > 0) ? ST_GAP : ST_IDLE;

    tag_state_t                state_q, state_d;
    logic [cnt_w_lp-1:0]       cnt_q, cnt_d;
    bsg_tag_cmd_s              cmd_q, cmd_d;
    logic                      tag_en_q, tag_en_d;
    logic                      ready_q, ready_d;
    logic                      busy_q, busy_d;
    logic                      piso_load, piso_shift;
    logic [max_payload_lp-1:0] piso_data;

    // Every state entry reloads the PISO, so single-bit fields and the idle zeros also come out of it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        piso_data  = '0;
        case (state_q)
            ST_IDLE: begin
                if (v_i) begin
                    cmd_d.nodeid         = nodeid_i;
                    cmd_d.data_not_reset = data_not_reset_i;
                    cmd_d.len            = len_i;
                    cmd_d.payload        = payload_i;
                    state_d   = ST_START;
                    cnt_d     = '0;
                    piso_load = 1'b1;
                    piso_data = max_payload_lp'(1);
                end
            end
            ST_START: begin
                state_d   = ST_NODE;
                cnt_d     = node_cnt_lp;
                piso_load = 1'b1;
                piso_data = max_payload_lp'(cmd_q.nodeid);
            end
            ST_NODE: begin
                if (cnt_q != '0) begin
                    cnt_d      = cnt_q - cnt_w_lp'(1);
                    piso_shift = 1'b1;
                end else begin
                    state_d   = ST_DNR;
                    cnt_d     = '0;
                    piso_load = 1'b1;
                    piso_data = max_payload_lp'(cmd_q.data_not_reset);
                end
            end
            ST_DNR: begin
                state_d   = ST_LEN;
                cnt_d     = len_cnt_lp;
                piso_load = 1'b1;
                piso_data = max_payload_lp'(cmd_q.len);
            end
            ST_LEN: begin
                if (cnt_q != '0) begin
                    cnt_d      = cnt_q - cnt_w_lp'(1);
                    piso_shift = 1'b1;
                end else if (cmd_q.len != '0) begin
                    state_d   = ST_PAYLOAD;
                    cnt_d     = cnt_w_lp'(cmd_q.len) - cnt_w_lp'(1);
                    piso_load = 1'b1;
                    piso_data = cmd_q.payload;
                end else begin
                    state_d   = after_pkt_lp;
                    cnt_d     = gap_cnt_lp;
                    piso_load = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                if (cnt_q != '0) begin
                    cnt_d      = cnt_q - cnt_w_lp'(1);
                    piso_shift = 1'b1;
                end else begin
                    state_d   = after_pkt_lp;
                    cnt_d     = gap_cnt_lp;
                    piso_load = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - cnt_w_lp'(1);
                end else begin
                    state_d   = ST_IDLE;
                    piso_load = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                piso_load = 1'b1;
            end
        endcase
    end

    always_comb begin
        tag_en_d = (state_d != ST_IDLE) && (state_d != ST_GAP);
        ready_d  = (state_d == ST_IDLE);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cmd_q    <= '0;
            tag_en_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            tag_en_q <= tag_en_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    bsg_tag_piso #(.width_p(max_payload_lp)) piso (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load_i    (piso_load),
        .shift_i   (piso_shift),
        .data_i    (piso_data),
        .bit_o     (tag_data_o)
    );

    assign tag_en_o = tag_en_q;
    assign ready_o  = ready_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_bsg_tag_packet_serializer.sv
// Scoreboard bench for bsg_tag_packet_serializer: expected per-cycle outputs are queued at drive time.
module tb_bsg_tag_packet_serializer;

    localparam int ELS  = 32;
    localparam int LG_ELS = 5;
    localparam int LG_W = 4;
    localparam int MAXP = 15;
    localparam int GAP  = 2;

    logic            clk_i = 1'b0;
    logic            reset_n_i = 1'b0;
    logic            v_i = 1'b0;
    logic [LG_ELS-1:0] nodeid_i = '0;
    logic            data_not_reset_i = 1'b0;
    logic [LG_W-1:0] len_i = '0;
    logic [MAXP-1:0] payload_i = '0;
    logic            ready_o, tag_data_o, tag_en_o, busy_o;

    always #5 clk_i = ~clk_i;

    bsg_tag_packet_serializer #(
        .els_p        (ELS),
        .lg_width_p   (LG_W),
        .gap_cycles_p (GAP)
    ) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .v_i              (v_i),
        .nodeid_i         (nodeid_i),
        .data_not_reset_i (data_not_reset_i),
        .len_i            (len_i),
        .payload_i        (payload_i),
        .ready_o          (ready_o),
        .tag_data_o       (tag_data_o),
        .tag_en_o         (tag_en_o),
        .busy_o           (busy_o)
    );

    // Expected output vector per cycle: {ready, busy, en, data}.
    localparam logic [3:0] EXP_IDLE = 4'b1000;
    localparam logic [3:0] EXP_GAP  = 4'b0100;

    logic [3:0] sb[$];
    int checks = 0;
    int passes = 0;
    bit done = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp)
            $display("[TB] FAIL %s: actual %0h required %0h", tag, got, exp);
        else
            passes++;
    endtask

    // Independent model of the packet bit order.
    task automatic modelBits(input logic [LG_ELS-1:0] node, input logic dnr, input logic [LG_W-1:0] len,
                             input logic [MAXP-1:0] pay, output logic [31:0] bits, output int n);
        bits = '0;
        n = 0;
        bits[n] = 1'b1; n++;
        for (int i = 0; i < LG_ELS; i++) begin bits[n] = node[i]; n++; end
        bits[n] = dnr; n++;
        for (int i = 0; i < LG_W; i++) begin bits[n] = len[i]; n++; end
        for (int i = 0; i < int'(len); i++) begin bits[n] = pay[i]; n++; end
    endtask

    task automatic pushBits(input logic [31:0] bits, input int n);
        sb.push_back(EXP_IDLE);
        for (int i = 0; i < n; i++) sb.push_back({3'b011, bits[i]});
        for (int i = 0; i < GAP; i++) sb.push_back(EXP_GAP);
    endtask

    task automatic scramble();
        nodeid_i         = LG_ELS'($urandom);
        data_not_reset_i = 1'($urandom);
        len_i            = LG_W'($urandom);
        payload_i        = MAXP'($urandom);
    endtask

    task automatic driveCmd(input logic [LG_ELS-1:0] node, input logic dnr, input logic [LG_W-1:0] len,
                            input logic [MAXP-1:0] pay);
        nodeid_i         = node;
        data_not_reset_i = dnr;
        len_i            = len;
        payload_i        = pay;
    endtask

    task automatic applyStimulus(input logic [LG_ELS-1:0] node, input logic dnr, input logic [LG_W-1:0] len,
                                 input logic [MAXP-1:0] pay, input logic [31:0] bits, input int n);
        @(posedge clk_i); #1;
        driveCmd(node, dnr, len, pay);
        v_i = 1'b1;
        pushBits(bits, n);
        @(posedge clk_i); #1;
        v_i = 1'b0;
        scramble();
    endtask

    task automatic applyModeled(input logic [LG_ELS-1:0] node, input logic dnr, input logic [LG_W-1:0] len,
                                input logic [MAXP-1:0] pay);
        logic [31:0] b;
        int n;
        modelBits(node, dnr, len, pay, b, n);
        applyStimulus(node, dnr, len, pay, b, n);
    endtask

    // v_i stays high through the first packet; the second command must wait for ready_o.
    task automatic applyPair(input logic [LG_ELS-1:0] n1, input logic d1, input logic [LG_W-1:0] l1,
                             input logic [MAXP-1:0] p1, input logic [LG_ELS-1:0] n2, input logic d2,
                             input logic [LG_W-1:0] l2, input logic [MAXP-1:0] p2);
        logic [31:0] b1, b2;
        int c1, c2;
        modelBits(n1, d1, l1, p1, b1, c1);
        modelBits(n2, d2, l2, p2, b2, c2);
        @(posedge clk_i); #1;
        driveCmd(n1, d1, l1, p1);
        v_i = 1'b1;
        pushBits(b1, c1);
        pushBits(b2, c2);
        @(posedge clk_i); #1;
        driveCmd(n2, d2, l2, p2);
        repeat (c1 + GAP + 1) @(posedge clk_i);
        #1;
        v_i = 1'b0;
        scramble();
    endtask

    task automatic waitIdle();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk_i);
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Cycle monitor, sampling on the falling edge.
    initial begin
        logic [3:0] got;
        logic [3:0] exp;
        forever begin
            @(negedge clk_i);
            if (!done) begin
                got = {ready_o, busy_o, tag_en_o, tag_data_o};
                if (!reset_n_i) begin
                    checkOutput($sformatf("in_reset@%0t", $time), 32'(got), 32'(EXP_IDLE));
                end else if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    checkOutput($sformatf("stream@%0t", $time), 32'(got), 32'(exp));
                end else begin
                    checkOutput($sformatf("idle@%0t", $time), 32'(got), 32'(EXP_IDLE));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout required finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        reset_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        #1;
        checkOutput("rst_ready", 32'(ready_o), 32'd1);
        checkOutput("rst_en",    32'(tag_en_o), 32'd0);
        checkOutput("rst_data",  32'(tag_data_o), 32'd0);
        checkOutput("rst_busy",  32'(busy_o), 32'd0);

        // Nominal packet; payload bits above len are deliberately set and must be ignored.
        applyStimulus(5'd19, 1'b1, 4'd3, 15'h7FFD, 32'b10100111100111, 14);
        waitIdle();

        applyModeled(5'd0, 1'b0, 4'd0, 15'h1234);
        waitIdle();

        applyModeled(5'd7, 1'b1, 4'd15, 15'h5A5A);
        waitIdle();

        applyPair(5'd5, 1'b1, 4'd2, 15'h0003, 5'd31, 1'b0, 4'd4, 15'h000A);
        waitIdle();

        for (int k = 0; k < 3; k++) begin
            applyModeled(LG_ELS'($urandom), 1'($urandom), LG_W'($urandom), MAXP'($urandom));
            waitIdle();
        end

        // Reset during the LEN field (first len bit is 1).
        applyModeled(5'd10, 1'b1, 4'd5, 15'h7FF5);
        repeat (7) @(posedge clk_i);
        #1;
        checkOutput("pre_reset_en",   32'(tag_en_o), 32'd1);
        checkOutput("pre_reset_data", 32'(tag_data_o), 32'd1);
        #1;
        reset_n_i = 1'b0;
        sb.delete();
        #1;
        checkOutput("async_rst_en",    32'(tag_en_o), 32'd0);
        checkOutput("async_rst_data",  32'(tag_data_o), 32'd0);
        checkOutput("async_rst_ready", 32'(ready_o), 32'd1);
        checkOutput("async_rst_busy",  32'(busy_o), 32'd0);
        repeat (2) @(negedge clk_i);
        #1 reset_n_i = 1'b1;

        applyModeled(5'd3, 1'b1, 4'd7, 15'h004B);
        waitIdle();
        repeat (3) @(posedge clk_i);

        done = 1'b1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bsg_tag_packet_serializer.md
Name: bsg_tag_packet_serializer

Overview:
- Host-side bsg_tag packet generator that sits directly upstream of the chip's bsg_tag master.
- Accepts one tag command per valid/ready handshake: client node id, data_not_reset flag, payload length and payload.
- Emits the command bit-serially on a tag data/enable pair that drives the chip's tag data and tag enable pins, so tag clients (clock-gen, IO complex, BP core/host/router reset+did) are programmed without a trace-replay ROM.

Parameters:
- els_p, 32: number of tag clients; node id width = lg_els_lp = $clog2(els_p).
- lg_width_p, 4: width of the length field; max payload width = max_payload_lp = 2^lg_width_p - 1.
- gap_cycles_p, 2: idle zero cycles forced after each packet; 0 is legal.

Ports:
- clk_i  in  1  tag clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  1  command valid.
- nodeid_i  in  lg_els_lp  target client id.
- data_not_reset_i  in  1  1 = data packet, 0 = client reset packet.
- len_i  in  lg_width_p  payload bit count, 0..max_payload_lp.
- payload_i  in  max_payload_lp  payload; bits at index >= len_i are ignored.
- ready_o  in/out: out  1  command accept.
- tag_data_o  out  1  serial tag data.
- tag_en_o  out  1  high while a packet bit is driven.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- One clock domain (clk_i). Reset is asynchronous and active-low (reset_n_i). All outputs are registered.
- Reset values: ready_o=1, tag_data_o=0, tag_en_o=0, busy_o=0, state=IDLE, latched fields and counter cleared.
- Handshake:
  - Accept when v_i & ready_o at a rising edge.
  - Fields are latched on that edge. Inputs after acceptance are don't-care.
  - ready_o=1 only in IDLE.
- FSM states and transitions: IDLE -> START -> NODE -> DNR -> LEN -> PAYLOAD -> GAP -> IDLE.
  - START: 1 cycle, tag_data_o=1.
  - NODE: lg_els_lp cycles, nodeid LSB first.
  - DNR: 1 cycle, tag_data_o = data_not_reset.
  - LEN: lg_width_p cycles, len LSB first.
  - PAYLOAD: len cycles, payload LSB first.
  - GAP: gap_cycles_p cycles, tag_data_o=0, tag_en_o=0.
- Skipped states:
  - len=0: LEN goes directly to GAP; no PAYLOAD cycles.
  - gap_cycles_p=0: the state after the last packet bit is IDLE.
- Latency: accept at edge t -> start bit valid in cycle t+1.
  - Packet length P = 2 + lg_els_lp + lg_width_p + len cycles.
  - ready_o high again in cycle t+1+P+gap_cycles_p.
- tag_en_o=1 exactly in START through PAYLOAD cycles; 0 otherwise.
- tag_data_o=0 whenever tag_en_o=0, so the master sees zeros between packets.
- Bit counting:
  - One shared down-counter of width max($clog2(max_payload_lp+1), lg_els_lp, lg_width_p, $clog2(gap_cycles_p+1)).
  - Loaded on each state entry; the state advances when it reaches 0.
  - No wrap-around is possible.
- Back-to-back commands: v_i held high is accepted only in IDLE. The minimum spacing is P+gap_cycles_p+1 cycles.
- Reset mid-packet:
  - Outputs clear immediately and asynchronously.
  - The partial packet is dropped; the master must be re-synced by host software.
  - The first command after reset deassertion is accepted normally.
- nodeid_i >= els_p: serialized unchanged. Not checked here; an assertion is permitted in simulation only.

Decomposition:
- Shared package bsg_tag_serializer_pkg holds:
  - bsg_tag_cmd_s packed struct {nodeid, data_not_reset, len, payload}, parameterized through a declare macro.
  - the FSM state enum.
  - helper localparam function for packet length.
- One natural sub-module: bsg_tag_piso, a parallel-in serial-out shift register with load/shift enable and LSB-first output, instantiated once with width max_payload_lp. Node id and len are shifted through it by loading at each state entry.

Test Plan:
- Reset: reset_n_i=0 for 3 cycles, then 1 -> ready_o=1, tag_en_o=0, tag_data_o=0, busy_o=0.
- Nominal packet: nodeid=19, dnr=1, len=3, payload=3'b101, accepted at t.
  - tag_data_o, cycles t+1..t+14 = 1, 1,1,0,0,1, 1, 1,1,0,0, 1,0,1.
  - tag_en_o=1 for exactly those 14 cycles.
  - Zeros in t+15..t+16; ready_o=1 at t+17.
- Zero-length reset packet: nodeid=0, dnr=0, len=0 -> 11 bits 1,0,0,0,0,0,0,0,0,0,0 with tag_en_o=1. Then 2 gap cycles; no payload cycles.
- Max payload: len=15, payload=15'h5A5A -> 26 enabled cycles. Payload bits emitted LSB first match 15'h5A5A. ready_o returns at t+29.
- Back-to-back with v_i held high: the second command is accepted exactly at the cycle ready_o rises. There are no overlapping enable cycles, and exactly gap_cycles_p zero cycles separate the two packets.
- Reset mid-packet: assert reset_n_i=0 during LEN.
  - tag_en_o/tag_data_o drop to 0 in the same cycle, before the next edge.
  - After release, a new command serializes correctly from its START bit.
